// File: rtl/board_reader.sv
// Scans the 64-cell gameboard RAM and tallies black/white/empty cells, then reports the winner.
// Define BOARD_READER_STREAM_EN to stream each captured cell out on cell_valid/cell_addr/cell_data.
module board_reader (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] data_in,
    output logic       ctrl_mem,
    output logic [6:0] addr,
    output logic       wren,
    output logic       busy,
    output logic       done,
    output logic [6:0] black_count,
    output logic [6:0] white_count,
    output logic [6:0] empty_count,
    output logic [1:0] winner,
    output logic       full,
    output logic       error,
    output logic       cell_valid,
    output logic [5:0] cell_addr,
    output logic [1:0] cell_data
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [6:0] LAST_ADDR = 7'd63;
    localparam logic [6:0] MAX_COUNT = 7'd64;

    state_t state, state_nxt;
    logic   accept;
    logic   vld_p0;
    logic   result_vld;

    function automatic logic [6:0] sat_inc(input logic [6:0] cnt);
        return (cnt >= MAX_COUNT) ? MAX_COUNT : cnt + 7'd1;
    endfunction

    function automatic logic [1:0] pick_winner(input logic [6:0] b, input logic [6:0] w);
        if (b > w)      return 2'b01;
        else if (w > b) return 2'b10;
        else            return 2'b00;
    endfunction

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ctrl_mem = (state == SCAN) || (state == DRAIN);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign wren     = 1'b0;

    // stage p0: address presented to RAM; the matching q arrives one cycle later
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= (state == SCAN);
            if (accept)
                addr <= '0;
            else if (state == SCAN && addr != LAST_ADDR)
                addr <= addr + 7'd1;
            else if (state == DRAIN)
                addr <= '0;
        end
    end

    // stage p1: capture data_in for the address presented in p0 and tally it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            black_count <= '0;
            white_count <= '0;
            empty_count <= '0;
            error       <= 1'b0;
            result_vld  <= 1'b0;
        end else if (accept) begin
            black_count <= '0;
            white_count <= '0;
            empty_count <= '0;
            error       <= 1'b0;
            result_vld  <= 1'b0;
        end else begin
            if (state == DRAIN)
                result_vld <= 1'b1;
            if (vld_p0) begin
                case (data_in)
                    2'b01:   black_count <= sat_inc(black_count);
                    2'b10:   white_count <= sat_inc(white_count);
                    default: empty_count <= sat_inc(empty_count);
                endcase
                if (data_in == 2'b11)
                    error <= 1'b1;
            end
        end
    end

    assign winner = pick_winner(black_count, white_count);
    // full only means something once a scan has completed; after reset the board is unknown
    assign full   = result_vld && (empty_count == 7'd0);

`ifdef BOARD_READER_STREAM_EN
    logic [5:0] addr_p0;

    always_ff @(posedge clock) begin
        addr_p0 <= addr[5:0];
    end

    assign cell_valid = vld_p0;
    assign cell_addr  = vld_p0 ? addr_p0 : 6'd0;
    assign cell_data  = vld_p0 ? data_in : 2'd0;
`else
    assign cell_valid = 1'b0;
    assign cell_addr  = 6'd0;
    assign cell_data  = 2'd0;
`endif

endmodule

// File: tb/tb_board_reader.sv
// Bench for board_reader: fixed board vectors, random boards against a counting model,
// start re-pulse and mid-scan reset sequences.
module tb_board_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] data_in;
    logic       ctrl_mem, wren, busy, done, full, error, cell_valid;
    logic [6:0] addr, black_count, white_count, empty_count;
    logic [1:0] winner, cell_data;
    logic [5:0] cell_addr;

    board_reader dut (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in),
        .ctrl_mem(ctrl_mem), .addr(addr), .wren(wren), .busy(busy), .done(done),
        .black_count(black_count), .white_count(white_count), .empty_count(empty_count),
        .winner(winner), .full(full), .error(error),
        .cell_valid(cell_valid), .cell_addr(cell_addr), .cell_data(cell_data)
    );

    always #5 clock = ~clock;

    // gameboard RAM with one cycle of read latency
    logic [1:0] mem [64];
    always @(posedge clock) data_in <= mem[addr[5:0]];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // reference: tally the board array directly
    int m_b, m_w, m_e, m_err, m_win, m_full;
    task automatic model_board();
        m_b = 0; m_w = 0; m_e = 0; m_err = 0;
        foreach (mem[i]) begin
            if (mem[i] == 2'b01)      m_b++;
            else if (mem[i] == 2'b10) m_w++;
            else begin
                m_e++;
                if (mem[i] == 2'b11) m_err = 1;
            end
        end
        m_win  = (m_b > m_w) ? 1 : (m_w > m_b) ? 2 : 0;
        m_full = (m_e == 0) ? 1 : 0;
    endtask

    typedef struct {
        int         kind;
        int         b, w, e;
        logic [1:0] win;
        bit         fl, er;
        string      name;
    } vec_t;

    task automatic fill_board(input int kind);
        foreach (mem[i]) mem[i] = 2'b00;
        case (kind)
            0: begin mem[27] = 2'b10; mem[36] = 2'b10; mem[28] = 2'b01; mem[35] = 2'b01; end
            1: foreach (mem[i]) mem[i] = 2'b01;
            2: begin for (int i = 0; i <= 9; i++) mem[i] = 2'b10; mem[5] = 2'b11; end
            3: ;
            4: foreach (mem[i]) mem[i] = 2'b10;
            default: foreach (mem[i]) mem[i] = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
        endcase
    endtask

    // Runs one scan for 80 cycles; cycle k is sampled 1 time unit after edge k-1 past the start edge.
    task automatic run_scan(input string tag, input int pa, input int pb);
        int done_cyc, ndone, bad_ctl, nvalid, stream_bad, next_a;
        logic [6:0] sb, sw, se;
        logic [1:0] swin;
        logic       serr, sfull;
        done_cyc = -1; ndone = 0; bad_ctl = 0; nvalid = 0; stream_bad = 0; next_a = 0;
        sb = 0; sw = 0; se = 0; swin = 0; serr = 0; sfull = 0;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    sb = black_count; sw = white_count; se = empty_count;
                    swin = winner; serr = error; sfull = full;
                end
            end
            if (ctrl_mem !== (k <= 65)) bad_ctl++;
            if (busy !== (k <= 66)) bad_ctl++;
            if (wren !== 1'b0) bad_ctl++;
`ifdef BOARD_READER_STREAM_EN
            if (cell_valid === 1'b1) begin
                nvalid++;
                if (next_a > 63 || cell_addr !== 6'(next_a) || cell_data !== mem[next_a[5:0]]) stream_bad++;
                next_a++;
            end
`else
            if (cell_valid !== 1'b0 || cell_addr !== 6'd0 || cell_data !== 2'd0) stream_bad++;
`endif
            start = (k == pa || k == pb);
            @(posedge clock); #1;
        end
        start = 1'b0;
        model_board();
        check({tag, " done_count"}, ndone, 1);
        check({tag, " done_cycle"}, done_cyc, 66);
        check({tag, " ctrl_busy_wren"}, bad_ctl, 0);
`ifdef BOARD_READER_STREAM_EN
        check({tag, " stream_pulses"}, nvalid, 64);
`endif
        check({tag, " stream"}, stream_bad, 0);
        check({tag, " black"}, black_count, m_b);
        check({tag, " white"}, white_count, m_w);
        check({tag, " empty"}, empty_count, m_e);
        check({tag, " winner"}, winner, m_win);
        check({tag, " full"}, full, m_full);
        check({tag, " error"}, error, m_err);
        check({tag, " addr_idle"}, addr, 0);
        check({tag, " hold"}, {sb, sw, se, swin, serr, sfull},
              {black_count, white_count, empty_count, winner, error, full});
    endtask

    vec_t vecs[5];

    initial begin
        reset = 1'b0; start = 1'b0;
        foreach (mem[i]) mem[i] = 2'b00;
        vecs[0] = '{0, 2, 2, 60, 2'b00, 1'b0, 1'b0, "opening"};
        vecs[1] = '{1, 64, 0, 0, 2'b01, 1'b1, 1'b0, "all_black"};
        vecs[2] = '{2, 0, 9, 55, 2'b10, 1'b0, 1'b1, "illegal5"};
        vecs[3] = '{3, 0, 0, 64, 2'b00, 1'b0, 1'b0, "all_empty"};
        vecs[4] = '{4, 0, 64, 0, 2'b10, 1'b1, 1'b0, "all_white"};

        #1;
        check("reset outputs", {ctrl_mem, addr, busy, done, black_count, white_count, empty_count,
                                winner, full, error, cell_valid, cell_addr, cell_data}, 0);
        repeat (3) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        check("idle after reset", {ctrl_mem, busy, done, full, error}, 0);

        foreach (vecs[v]) begin
            fill_board(vecs[v].kind);
            run_scan(vecs[v].name, 0, 0);
            check({vecs[v].name, " tbl_counts"}, {black_count, white_count, empty_count},
                  {7'(vecs[v].b), 7'(vecs[v].w), 7'(vecs[v].e)});
            check({vecs[v].name, " tbl_flags"}, {winner, full, error},
                  {vecs[v].win, vecs[v].fl, vecs[v].er});
        end

        for (int r = 0; r < 6; r++) begin
            fill_board(9);
            run_scan($sformatf("random%0d", r), 0, 0);
        end

        fill_board(0);
        run_scan("repulse", 10, 40);

        // reset in the middle of a scan
        fill_board(1);
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        for (int k = 1; k < 30; k++) begin @(posedge clock); #1; end
        check("midscan black", black_count, 28);
        #2 reset = 1'b0;
        #1;
        check("midreset outputs", {ctrl_mem, busy, done, addr, black_count, white_count,
                                   empty_count, winner, full, error}, 0);
        @(negedge clock); reset = 1'b1;
        begin
            int extra_done, late_busy;
            extra_done = 0; late_busy = 0;
            for (int k = 0; k < 100; k++) begin
                @(posedge clock); #1;
                if (done !== 1'b0) extra_done++;
                if (busy !== 1'b0 || ctrl_mem !== 1'b0) late_busy++;
            end
            check("no done after reset", extra_done, 0);
            check("idle after midreset", late_busy, 0);
            check("counts after midreset", {black_count, white_count, empty_count}, 0);
        end

        fill_board(2);
        run_scan("after_reset", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
